// File: rtl/sample_frame_sequencer.sv
// Per-tick audio frame sequencer. Each accepted tick runs one frame: ADC conversion, then the
// processor, then the DAC load. Ticks that arrive mid-frame and missing strobes are counted.
`timescale 1ns/1ps
module sample_frame_sequencer #(
  parameter int DW       = 10,
  parameter int TIMEOUT  = 2000,
  parameter int DAC_HOLD = 1200,
  parameter int CNT_W    = 8
) (
  input  logic             sysclk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             enable_i,
  output logic             adc_start_o,
  input  logic             adc_valid_i,
  input  logic [DW-1:0]    adc_data_i,
  output logic             proc_strobe_o,
  output logic [DW-1:0]    proc_din_o,
  input  logic             proc_done_i,
  input  logic [DW-1:0]    proc_dout_i,
  output logic             dac_load_o,
  output logic [DW-1:0]    dac_data_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] overrun_cnt_o,
  output logic [CNT_W-1:0] timeout_cnt_o
);

  localparam int TMAX = (TIMEOUT > DAC_HOLD) ? TIMEOUT : DAC_HOLD;
  localparam int TW   = $clog2(TMAX + 1);

  // Each WAIT state loads the timer with its length minus one and leaves at terminal count 0.
  localparam logic [TW-1:0]    WAIT_LOAD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    HOLD_LOAD = TW'(DAC_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADC_START  = 3'd1,
    ADC_WAIT   = 3'd2,
    PROC_START = 3'd3,
    PROC_WAIT  = 3'd4,
    DAC_START  = 3'd5,
    DAC_WAIT   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [DW-1:0]    proc_din_q, proc_din_d;
  logic [DW-1:0]    dac_data_q, dac_data_d;
  logic             adc_start_q, adc_start_d;
  logic             proc_strobe_q, proc_strobe_d;
  logic             dac_load_q, dac_load_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] overrun_q, overrun_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic             timer_tc;

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      proc_din_q    <= '0;
      dac_data_q    <= '0;
      adc_start_q   <= 1'b0;
      proc_strobe_q <= 1'b0;
      dac_load_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      proc_din_q    <= proc_din_d;
      dac_data_q    <= dac_data_d;
      adc_start_q   <= adc_start_d;
      proc_strobe_q <= proc_strobe_d;
      dac_load_q    <= dac_load_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    proc_din_d = proc_din_q;
    dac_data_d = dac_data_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    timer_tc   = (timer_q == '0);

    if (tick_i && (state_q != IDLE) && (overrun_q != CNT_MAX)) begin
      overrun_d = overrun_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tick_i && enable_i) state_d = ADC_START;
      end
      ADC_START: begin
        state_d = ADC_WAIT;
        timer_d = WAIT_LOAD;
      end
      ADC_WAIT: begin
        // A strobe on the terminal-count cycle still wins over the timeout.
        if (adc_valid_i) begin
          proc_din_d = adc_data_i;
          state_d    = PROC_START;
        end else if (timer_tc) begin
          state_d = IDLE;
          if (timeout_q != CNT_MAX) timeout_d = timeout_q + CNT_W'(1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      PROC_START: begin
        state_d = PROC_WAIT;
        timer_d = WAIT_LOAD;
      end
      PROC_WAIT: begin
        if (proc_done_i) begin
          dac_data_d = proc_dout_i;
          state_d    = DAC_START;
        end else if (timer_tc) begin
          state_d = IDLE;
          if (timeout_q != CNT_MAX) timeout_d = timeout_q + CNT_W'(1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DAC_START: begin
        state_d = DAC_WAIT;
        timer_d = HOLD_LOAD;
      end
      DAC_WAIT: begin
        if (timer_tc) state_d = IDLE;
        else          timer_d = timer_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase

    adc_start_d   = (state_d == ADC_START);
    proc_strobe_d = (state_d == PROC_START);
    dac_load_d    = (state_d == DAC_START);
    busy_d        = (state_d != IDLE);
  end

  assign adc_start_o   = adc_start_q;
  assign proc_strobe_o = proc_strobe_q;
  assign proc_din_o    = proc_din_q;
  assign dac_load_o    = dac_load_q;
  assign dac_data_o    = dac_data_q;
  assign busy_o        = busy_q;
  assign overrun_cnt_o = overrun_q;
  assign timeout_cnt_o = timeout_q;

endmodule

// File: tb/tb_sample_frame_sequencer.sv
// Bench for sample_frame_sequencer: a deadline-based frame model checked every cycle, directed
// scenarios with literal expectations, then randomized ticks, strobes and enable.
`timescale 1ns/1ps
module tb_sample_frame_sequencer;

  localparam int DW       = 10;
  localparam int TIMEOUT  = 2000;
  localparam int DAC_HOLD = 1200;
  localparam int CNT_W    = 8;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0, en = 1'b1;
  logic             av = 1'b0, pd = 1'b0;
  logic [DW-1:0]    ad = '0, pdo = '0;
  logic             adc_start_o, proc_strobe_o, dac_load_o, busy_o;
  logic [DW-1:0]    proc_din_o, dac_data_o;
  logic [CNT_W-1:0] overrun_cnt_o, timeout_cnt_o;

  int checks = 0;
  int failures = 0;

  sample_frame_sequencer #(.DW(DW), .TIMEOUT(TIMEOUT), .DAC_HOLD(DAC_HOLD), .CNT_W(CNT_W)) dut (
    .sysclk_i(clk), .rst_i(rst), .tick_i(tick), .enable_i(en),
    .adc_start_o(adc_start_o), .adc_valid_i(av), .adc_data_i(ad),
    .proc_strobe_o(proc_strobe_o), .proc_din_o(proc_din_o),
    .proc_done_i(pd), .proc_dout_i(pdo),
    .dac_load_o(dac_load_o), .dac_data_o(dac_data_o), .busy_o(busy_o),
    .overrun_cnt_o(overrun_cnt_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a sequence of deadline windows measured in clock edges.
  localparam int M_IDLE = 0, M_ADC = 1, M_PROC = 2, M_HOLD = 3;
  int            edge_n = 0;
  int            m_mode = M_IDLE;
  int            win_lo = 0, win_hi = 0;
  int            m_ovr = 0, m_to = 0;
  bit            m_adc_start = 0, m_proc_strobe = 0, m_dac_load = 0;
  logic [DW-1:0] m_pdin = '0, m_dac = '0;

  always @(posedge clk) begin
    edge_n++;
    m_adc_start = 0; m_proc_strobe = 0; m_dac_load = 0;
    if (rst) begin
      m_mode = M_IDLE; m_ovr = 0; m_to = 0; m_pdin = '0; m_dac = '0;
    end else begin
      if (m_mode != M_IDLE && tick && m_ovr < CMAX) m_ovr++;
      case (m_mode)
        M_IDLE: if (tick && en) begin
          m_mode = M_ADC; win_lo = edge_n + 2; win_hi = edge_n + 1 + TIMEOUT; m_adc_start = 1;
        end
        M_ADC: if (edge_n >= win_lo) begin
          if (av) begin
            m_pdin = ad; m_proc_strobe = 1; m_mode = M_PROC;
            win_lo = edge_n + 2; win_hi = edge_n + 1 + TIMEOUT;
          end else if (edge_n == win_hi) begin
            m_mode = M_IDLE; if (m_to < CMAX) m_to++;
          end
        end
        M_PROC: if (edge_n >= win_lo) begin
          if (pd) begin
            m_dac = pdo; m_dac_load = 1; m_mode = M_HOLD; win_hi = edge_n + 1 + DAC_HOLD;
          end else if (edge_n == win_hi) begin
            m_mode = M_IDLE; if (m_to < CMAX) m_to++;
          end
        end
        default: if (edge_n == win_hi) m_mode = M_IDLE;
      endcase
    end
    #1;
    chk("cmp_adc_start", adc_start_o, m_adc_start);
    chk("cmp_proc_strobe", proc_strobe_o, m_proc_strobe);
    chk("cmp_proc_din", proc_din_o, m_pdin);
    chk("cmp_dac_load", dac_load_o, m_dac_load);
    chk("cmp_dac_data", dac_data_o, m_dac);
    chk("cmp_busy", busy_o, m_mode != M_IDLE);
    chk("cmp_overrun", overrun_cnt_o, m_ovr);
    chk("cmp_timeout", timeout_cnt_o, m_to);
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy_o, 0);
  endtask

  function automatic int pick_delay();
    case ($urandom_range(0, 4))
      0:       return 1;
      1:       return TIMEOUT;
      2:       return TIMEOUT + 1;
      3:       return int'($urandom_range(1, TIMEOUT + 300));
      default: return int'($urandom_range(1, 60));
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int adc_cd = 0;
    int proc_cd = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy_o, 0);
    chk("reset_dac_data", dac_data_o, 0);
    chk("reset_proc_din", proc_din_o, 0);
    chk("reset_overrun", overrun_cnt_o, 0);
    repeat (2) @(negedge clk);

    // Frame with literal latencies: tick at t0.
    tick = 1; @(negedge clk); tick = 0;
    chk("t1_adc_start", adc_start_o, 1);
    @(negedge clk);
    chk("t1_adc_start_1cyc", adc_start_o, 0);
    repeat (38) @(negedge clk);
    av = 1; ad = 10'h155; @(negedge clk); av = 0;
    chk("t1_proc_strobe", proc_strobe_o, 1);
    chk("t1_proc_din", proc_din_o, 10'h155);
    repeat (19) @(negedge clk);
    pd = 1; pdo = 10'h2AA; @(negedge clk); pd = 0;
    chk("t1_dac_load", dac_load_o, 1);
    chk("t1_dac_data", dac_data_o, 10'h2AA);
    repeat (DAC_HOLD) @(negedge clk);
    chk("t1_busy_last_hold", busy_o, 1);
    @(negedge clk);
    chk("t1_busy_fall", busy_o, 0);

    // Overrun during PROC_WAIT.
    tick = 1; @(negedge clk); tick = 0;
    repeat (4) @(negedge clk);
    av = 1; ad = 10'h0C3; @(negedge clk); av = 0;
    repeat (2) @(negedge clk);
    tick = 1; @(negedge clk); tick = 0;
    chk("t2_overrun", overrun_cnt_o, 1);
    chk("t2_no_adc_start", adc_start_o, 0);
    pd = 1; pdo = 10'h0F3; @(negedge clk); pd = 0;
    chk("t2_dac_load", dac_load_o, 1);
    wait_idle(DAC_HOLD + 10);

    // Missing adc_valid times out.
    tick = 1; @(negedge clk); tick = 0;
    chk("t3_adc_start", adc_start_o, 1);
    repeat (TIMEOUT) @(negedge clk);
    chk("t3_busy_last_wait", busy_o, 1);
    chk("t3_no_timeout_yet", timeout_cnt_o, 0);
    @(negedge clk);
    chk("t3_busy", busy_o, 0);
    chk("t3_timeout", timeout_cnt_o, 1);
    chk("t3_dac_kept", dac_data_o, 10'h0F3);

    // enable low ignores tick; enable dropped mid-frame.
    en = 0; tick = 1; @(negedge clk); tick = 0;
    chk("t4_ignored_start", adc_start_o, 0);
    chk("t4_ignored_busy", busy_o, 0);
    chk("t4_overrun_same", overrun_cnt_o, 1);
    en = 1; tick = 1; @(negedge clk); tick = 0;
    chk("t4_adc_start", adc_start_o, 1);
    repeat (2) @(negedge clk);
    en = 0;
    repeat (7) @(negedge clk);
    av = 1; ad = 10'h3FF; @(negedge clk); av = 0;
    chk("t4_proc_din", proc_din_o, 10'h3FF);
    repeat (9) @(negedge clk);
    pd = 1; pdo = 10'h1A5; @(negedge clk); pd = 0;
    chk("t4_dac_load", dac_load_o, 1);
    chk("t4_dac_data", dac_data_o, 10'h1A5);
    en = 1;
    wait_idle(DAC_HOLD + 10);

    // 300 ticks during one frame saturate the overrun counter.
    tick = 1; @(negedge clk); tick = 0;
    for (int i = 0; i < 300; i++) begin
      tick = 1; @(negedge clk); tick = 0; @(negedge clk);
    end
    chk("t5_overrun_sat", overrun_cnt_o, 255);
    wait_idle(TIMEOUT + 10);
    chk("t5_timeout", timeout_cnt_o, 2);

    // Reset during DAC_WAIT, then a full frame with a tick on the last hold cycle.
    tick = 1; @(negedge clk); tick = 0;
    @(negedge clk); av = 1; ad = 10'h2C7;
    @(negedge clk); av = 0;
    @(negedge clk); pd = 1; pdo = 10'h155;
    @(negedge clk); pd = 0;
    chk("t6_dac_load", dac_load_o, 1);
    repeat (100) @(negedge clk);
    chk("t6_busy_hold", busy_o, 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_dac_data", dac_data_o, 0);
    chk("t6_rst_proc_din", proc_din_o, 0);
    chk("t6_rst_overrun", overrun_cnt_o, 0);
    chk("t6_rst_timeout", timeout_cnt_o, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    tick = 1; @(negedge clk); tick = 0;
    chk("t6_adc_start", adc_start_o, 1);
    @(negedge clk); av = 1; ad = 10'h2C7;
    @(negedge clk); av = 0;
    chk("t6_proc_din", proc_din_o, 10'h2C7);
    @(negedge clk); pd = 1; pdo = 10'h31E;
    @(negedge clk); pd = 0;
    chk("t6_dac_data", dac_data_o, 10'h31E);
    repeat (DAC_HOLD) @(negedge clk);
    tick = 1; @(negedge clk); tick = 0;
    chk("t6_last_hold_overrun", overrun_cnt_o, 1);
    chk("t6_last_hold_no_start", adc_start_o, 0);
    chk("t6_idle_after_hold", busy_o, 0);
    tick = 1; @(negedge clk); tick = 0;
    chk("t6_restart", adc_start_o, 1);
    wait_idle(TIMEOUT + 10);

    // Randomized traffic.
    for (int c = 0; c < 45000; c++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 299) == 0);
      en   = ($urandom_range(0, 9) != 0);
      av = 0; pd = 0;
      if (adc_cd > 0) begin
        adc_cd--;
        if (adc_cd == 0) begin av = 1; ad = DW'($urandom); end
      end
      if (proc_cd > 0) begin
        proc_cd--;
        if (proc_cd == 0) begin pd = 1; pdo = DW'($urandom); end
      end
      if ($urandom_range(0, 499) == 0) begin av = 1; ad = DW'($urandom); end
      if ($urandom_range(0, 499) == 0) begin pd = 1; pdo = DW'($urandom); end
      if (adc_start_o) adc_cd = pick_delay();
      if (proc_strobe_o) proc_cd = pick_delay();
    end
    @(negedge clk);
    tick = 0; av = 0; pd = 0; en = 1;
    wait_idle(TIMEOUT * 2 + DAC_HOLD + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
